inst_encoder: RTL and testbench

//  Inverse of the core's immediate decoder: packs opcode/funct/register fields plus a
//  32-bit immediate into an RV32I instruction word for formats R/I/S/B/U/J. One

---
 rtl/inst_encoder_pkg.sv | 39 +++
 rtl/inst_encoder_pack.sv | 65 ++++++
 rtl/inst_encoder.sv | 122 ++++++++++++
 tb/tb_inst_encoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, opcodes,
// the canonical NOP and a signed-range helper used by the legality checks.
package inst_encoder_pkg;

    // Instruction format selector carried on in_fmt; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // True when imm is a sign-extended value whose sign bit sits at position msb,
    // i.e. every bit from msb upward equals bit msb.
    function automatic logic fits_signed(input logic [31:0] imm, input logic [4:0] msb);
        logic [31:0] hi;
        hi = 32'($signed(imm) >>> msb);
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Purely combinational field packer: request fields -> {instruction word, illegal flag}.
// Illegal immediates are still packed from their truncated bits; illegal formats give a NOP.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic is_shift_s;

    // Shift-immediate instructions carry funct7 in the top bits and a 5-bit shamt.
    assign is_shift_s = (opcode == OP_IMM) &&
                        ((funct3 == F3_SLLI) || (funct3 == F3_SRLI_SRAI));

    // Select the bit layout for the requested format and judge the immediate's range.
    always_comb begin
        inst = NOP_INST;
        err  = 1'b0;
        case (fmt)
            FMT_R: begin
                inst = {funct7, rs2, rs1, funct3, rd, opcode};
                err  = 1'b0;
            end
            FMT_I: begin
                if (is_shift_s) begin
                    inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    err  = (imm[31:5] != 27'd0);
                end else begin
                    inst = {imm[11:0], rs1, funct3, rd, opcode};
                    err  = !fits_signed(imm, 5'd11);
                end
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !fits_signed(imm, 5'd11);
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !fits_signed(imm, 5'd12) || imm[0];
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode};
                err  = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !fits_signed(imm, 5'd20) || imm[0];
            end
            default: begin
                inst = NOP_INST;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: one registered stage with valid/ready on both sides,
// a byte-address counter for streaming into instruction memory, and a saturating
// count of accepted illegal requests.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    logic                 valid_q, valid_d;
    logic [31:0]          inst_q, inst_d;
    logic [31:0]          addr_q, addr_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [31:0]          pack_inst_s;
    logic                 pack_err_s;
    logic                 accept_s;
    logic                 out_fire_s;

    inst_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .inst   (pack_inst_s),
        .err    (pack_err_s)
    );

    // The stage can take a request whenever it is empty or its word leaves this cycle.
    assign in_ready   = !valid_q || out_ready;
    // A request in a flush cycle is dropped, so it is never counted as accepted.
    assign accept_s   = in_valid && in_ready && !flush;
    assign out_fire_s = valid_q && out_ready;

    // Next-state for the stage, address counter and error counter.
    always_comb begin
        valid_d   = valid_q;
        inst_d    = inst_q;
        err_d     = err_q;
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;

        if (flush) begin
            valid_d = 1'b0;
            inst_d  = 32'h0000_0000;
            err_d   = 1'b0;
            addr_d  = BASE_ADDR;
        end else begin
            if (out_fire_s) begin
                addr_d  = addr_q + 32'd4;
                valid_d = 1'b0;
            end else begin
                addr_d  = addr_q;
            end
            if (accept_s) begin
                valid_d = 1'b1;
                inst_d  = pack_inst_s;
                err_d   = pack_err_s;
            end else begin
                inst_d  = inst_q;
            end
        end

        if (accept_s && pack_err_s && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Stage registers; reset takes priority over flush and discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            inst_q    <= 32'h0000_0000;
            err_q     <= 1'b0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else begin
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_addr  = addr_q;
    assign out_err   = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, handshake, address
// counter, backpressure, flush, reset and error-counter saturation.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    inst_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0;
        in_funct7 = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'h0000_0000);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_addr", out_addr, BASE);
        chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADDI x1, x0, -1
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_inst", out_inst, 32'hFFF0_0093);
        chk("addi_err", {31'd0, out_err}, 32'd0);
        chk("addi_addr", out_addr, BASE);
        tick();
        chk("addi_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("addi_drain_addr", out_addr, BASE + 32'd4);

        // Flush back to BASE, then SW / BEQ back-to-back
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_addr", out_addr, BASE);
        req(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd3, 5'd2, 32'd8);
        tick();
        chk("sw_inst", out_inst, 32'h0021_A423);
        chk("sw_addr", out_addr, BASE);
        req(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        tick();
        chk("beq_valid", {31'd0, out_valid}, 32'd1);
        chk("beq_inst", out_inst, 32'hFE00_0EE3);
        chk("beq_addr", out_addr, BASE + 32'd4);

        // LUI x5 / JAL x1 back-to-back
        req(3'd4, 7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        tick();
        chk("lui_inst", out_inst, 32'h1234_52B7);
        chk("lui_err", {31'd0, out_err}, 32'd0);
        chk("lui_addr", out_addr, BASE + 32'd8);
        req(3'd5, 7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        chk("jal_inst", out_inst, 32'h0010_00EF);
        chk("jal_addr", out_addr, BASE + 32'd12);

        // Legal boundaries
        req(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094);
        tick();
        chk("b4094_inst", out_inst, 32'h7E00_0FE3);
        chk("b4094_err", {31'd0, out_err}, 32'd0);
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
        tick();
        chk("i2047_inst", out_inst, 32'h7FF0_0093);
        chk("i2047_err", {31'd0, out_err}, 32'd0);
        chk("legal_errcnt", {24'd0, err_cnt}, 32'd0);

        // Illegal requests
        req(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        tick();
        chk("b3_err", {31'd0, out_err}, 32'd1);
        chk("b3_errcnt", {24'd0, err_cnt}, 32'd1);
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        tick();
        chk("i4096_err", {31'd0, out_err}, 32'd1);
        chk("i4096_errcnt", {24'd0, err_cnt}, 32'd2);
        req(3'd1, 7'b0010011, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32);
        tick();
        chk("slli32_inst", out_inst, 32'h0000_9093);
        chk("slli32_err", {31'd0, out_err}, 32'd1);
        chk("slli32_errcnt", {24'd0, err_cnt}, 32'd3);
        req(3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd2, 5'd3, 5'd0, 32'd5);
        tick();
        chk("srai5_inst", out_inst, 32'h4051_D113);
        chk("srai5_err", {31'd0, out_err}, 32'd0);
        chk("srai5_errcnt", {24'd0, err_cnt}, 32'd3);
        req(3'd7, 7'b0110011, 3'b111, 7'd0, 5'd7, 5'd7, 5'd7, 32'd0);
        tick();
        chk("fmt7_inst", out_inst, 32'h0000_0013);
        chk("fmt7_err", {31'd0, out_err}, 32'd1);
        chk("fmt7_errcnt", {24'd0, err_cnt}, 32'd4);

        // Backpressure: hold word A for 3 cycles while B waits
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        tick();
        chk("bp_a_inst", out_inst, 32'h0010_0093);
        chk("bp_a_addr", out_addr, BASE);
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_hold_inst", out_inst, 32'h0010_0093);
            chk("bp_hold_addr", out_addr, BASE);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_b_inst", out_inst, 32'h0020_0093);
        chk("bp_b_addr", out_addr, BASE + 32'd4);

        // Flush during stall drops the held word and the concurrent request
        tick();
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_addr", out_addr, BASE);
        chk("fl_errcnt", {24'd0, err_cnt}, 32'd4);
        out_ready = 1'b1;
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        in_valid = 1'b0;
        chk("fl_c_inst", out_inst, 32'h0030_0093);
        chk("fl_c_addr", out_addr, BASE);

        // Error counter saturates at all-ones
        req(3'd6, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 260; i++) tick();
        in_valid = 1'b0;
        chk("sat_errcnt", {24'd0, err_cnt}, 32'd255);

        // Reset mid-stall
        out_ready = 1'b0;
        req(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_inst", out_inst, 32'h0000_0000);
        chk("mrst_err", {31'd0, out_err}, 32'd0);
        chk("mrst_addr", out_addr, BASE);
        chk("mrst_errcnt", {24'd0, err_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
